// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: operand-forward selects and MDU tracker states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones, clr wins over inc.
// One-cycle update latency; no backpressure.
module hazard_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use/MDU stalls, branch flushes, perf counters.
// Controls are combinational from current inputs; only MDU tracking and counters are registered.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              mdu_op_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              pc_src_e,
  input  logic              result_src_e,
  input  logic              mdu_start_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              mdu_done,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic              cnt_clr,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  mdu_state_e        state, stateNext;
  logic [REG_AW-1:0] pendRd, pendRdNext;
  logic              mduWait;
  logic              loadStall, rawStall, structStall, dStall;

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdM,
    input logic [REG_AW-1:0] rdW,
    input logic              wrM,
    input logic              wrW
  );
    if (wrM && (rs != '0) && (rs == rdM)) return FWD_MEM;
    if (wrW && (rs != '0) && (rs == rdW)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign forward_ae = fwdSel(rs1_e, rd_m, rd_w, regwrite_m, regwrite_w);
  assign forward_be = fwdSel(rs2_e, rd_m, rd_w, regwrite_m, regwrite_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pendRd <= '0;
    end else begin
      state  <= stateNext;
      pendRd <= pendRdNext;
    end
  end

  // A new issue always retargets the tracker, even when it lands on the completing cycle.
  always_comb begin
    stateNext  = state;
    pendRdNext = pendRd;
    case (state)
      IDLE: begin
        if (mdu_start_e) begin
          stateNext  = BUSY;
          pendRdNext = rd_e;
        end
      end
      BUSY: begin
        if (mdu_start_e) begin
          pendRdNext = rd_e;
        end else if (mdu_done) begin
          stateNext = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    mdu_busy = (state == BUSY);
  end

  // Write-through regfile: the completing cycle already delivers the result, so no stall.
  assign mduWait     = mdu_busy & ~mdu_done;
  assign loadStall   = result_src_e & (rd_e != '0) & ((rs1_d == rd_e) | (rs2_d == rd_e));
  assign rawStall    = mduWait & (pendRd != '0) &
                       ((rs1_d == pendRd) | (rs2_d == pendRd) | (rd_d == pendRd));
  assign structStall = mdu_op_d & (mduWait | mdu_start_e);
  assign dStall      = loadStall | rawStall | structStall;

  assign stall_f = dStall & ~pc_src_e;
  assign stall_d = dStall & ~pc_src_e;
  assign flush_d = pc_src_e;
  assign flush_e = pc_src_e | dStall;

  hazard_sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stall_d),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (pc_src_e),
    .count (flush_cnt)
  );

  // The reported completion must belong to the operation being tracked.
  mduRdMatch: assert property (@(posedge clk) disable iff (!rst_n)
    (mdu_done && mdu_busy) |-> (mdu_rd == pendRd));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mdu_rd;
  logic          mdu_op_d, pc_src_e, result_src_e, mdu_start_e;
  logic          regwrite_m, regwrite_w, mdu_done, cnt_clr;
  logic          stall_f, stall_d, flush_d, flush_e, mdu_busy;
  logic [1:0]    forward_ae, forward_be;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .mdu_op_d(mdu_op_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .pc_src_e(pc_src_e), .result_src_e(result_src_e), .mdu_start_e(mdu_start_e),
    .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .mdu_done(mdu_done), .mdu_rd(mdu_rd), .cnt_clr(cnt_clr),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward_ae(forward_ae), .forward_be(forward_be), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Model: is an MDU op outstanding, which register it targets, and the two event tallies.
  bit mBusy;
  int mPend, mStall, mFlush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int expFwd(input int rs);
    if (regwrite_m && rs != 0 && rs == int'(rd_m)) return 2;
    if (regwrite_w && rs != 0 && rs == int'(rd_w)) return 1;
    return 0;
  endfunction

  function automatic bit expDStall();
    bit waiting, ld, raw, st;
    waiting = mBusy && !mdu_done;
    ld  = result_src_e && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e);
    raw = waiting && mPend != 0 &&
          (int'(rs1_d) == mPend || int'(rs2_d) == mPend || int'(rd_d) == mPend);
    st  = mdu_op_d && (waiting || mdu_start_e);
    return ld || raw || st;
  endfunction

  task automatic compareAll();
    bit ds, stl;
    ds  = expDStall();
    stl = ds && !pc_src_e;
    check("stall_f", 32'(stall_f), 32'(stl));
    check("stall_d", 32'(stall_d), 32'(stl));
    check("flush_d", 32'(flush_d), 32'(pc_src_e));
    check("flush_e", 32'(flush_e), 32'(pc_src_e || ds));
    check("forward_ae", 32'(forward_ae), 32'(expFwd(int'(rs1_e))));
    check("forward_be", 32'(forward_be), 32'(expFwd(int'(rs2_e))));
    check("mdu_busy", 32'(mdu_busy), 32'(mBusy));
    check("stall_cnt", 32'(stall_cnt), 32'(mStall));
    check("flush_cnt", 32'(flush_cnt), 32'(mFlush));
  endtask

  task automatic modelReset();
    mBusy = 1'b0; mPend = 0; mStall = 0; mFlush = 0;
  endtask

  task automatic modelEdge();
    bit stl;
    stl = expDStall() && !pc_src_e;
    if (cnt_clr) begin
      mStall = 0; mFlush = 0;
    end else begin
      if (stl && mStall < CMAX) mStall++;
      if (pc_src_e && mFlush < CMAX) mFlush++;
    end
    if (mdu_start_e) begin
      mBusy = 1'b1; mPend = int'(rd_e);
    end else if (mdu_done) begin
      mBusy = 1'b0;
    end
  endtask

  task automatic clearIn();
    rs1_d = '0; rs2_d = '0; rd_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    rd_m = '0; rd_w = '0; mdu_rd = '0;
    mdu_op_d = 0; pc_src_e = 0; result_src_e = 0; mdu_start_e = 0;
    regwrite_m = 0; regwrite_w = 0; mdu_done = 0; cnt_clr = 0;
  endtask

  task automatic randIn();
    rs1_d = AW'($urandom_range(0, 7)); rs2_d = AW'($urandom_range(0, 7));
    rd_d  = AW'($urandom_range(0, 7)); rs1_e = AW'($urandom_range(0, 7));
    rs2_e = AW'($urandom_range(0, 7)); rd_e  = AW'($urandom_range(0, 7));
    rd_m  = AW'($urandom_range(0, 7)); rd_w  = AW'($urandom_range(0, 7));
    regwrite_m   = ($urandom_range(0, 1) == 0);
    regwrite_w   = ($urandom_range(0, 1) == 0);
    mdu_op_d     = ($urandom_range(0, 5) == 0);
    pc_src_e     = ($urandom_range(0, 7) == 0);
    result_src_e = ($urandom_range(0, 3) == 0);
    mdu_start_e  = ($urandom_range(0, 7) == 0);
    cnt_clr      = ($urandom_range(0, 63) == 0);
    mdu_done     = mBusy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
    mdu_rd       = (mdu_done && mBusy) ? AW'(mPend) : AW'($urandom_range(0, 31));
  endtask

  // Inputs change 1 unit after a rising edge; outputs are compared on the falling edge.
  task automatic settle();
    #4;
    compareAll();
  endtask

  task automatic edgeStep();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    clearIn();
    modelReset();
    rst_n = 1'b0;
    #3;
    compareAll();
    check("rst_busy", 32'(mdu_busy), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    #9;
    rst_n = 1'b1;
    edgeStep();

    // Forwarding priority and x0 exclusion
    clearIn(); rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1; rs1_e = 5;
    settle();
    check("fwd_mem_pri", 32'(forward_ae), 32'h2);
    edgeStep();
    clearIn(); rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1; rs1_e = 0;
    settle();
    check("fwd_x0", 32'(forward_ae), 32'h0);
    edgeStep();
    clearIn(); rd_m = 5; regwrite_m = 1; rd_w = 6; regwrite_w = 1; rs2_e = 6;
    settle();
    check("fwd_wb_b", 32'(forward_be), 32'h1);
    edgeStep();

    // Load-use stall for one cycle, none when the load targets x0
    clearIn(); result_src_e = 1; rd_e = 7; rs2_d = 7;
    settle();
    check("load_stall_f", 32'(stall_f), 32'd1);
    check("load_stall_d", 32'(stall_d), 32'd1);
    check("load_flush_e", 32'(flush_e), 32'd1);
    edgeStep();
    clearIn();
    settle();
    check("load_released", 32'(stall_d), 32'd0);
    edgeStep();
    clearIn(); result_src_e = 1; rd_e = 0; rs2_d = 0;
    settle();
    check("load_x0_stall", 32'(stall_d), 32'd0);
    check("load_x0_flush", 32'(flush_e), 32'd0);
    edgeStep();

    // MDU RAW stall released on the done cycle
    clearIn(); cnt_clr = 1; settle(); edgeStep();
    clearIn(); mdu_start_e = 1; rd_e = 9; settle(); edgeStep();
    for (int c = 1; c <= 4; c++) begin
      clearIn(); rs1_d = 9;
      if (c == 4) begin mdu_done = 1; mdu_rd = 9; end
      settle();
      check($sformatf("mdu_raw_c%0d", c), 32'(stall_d), (c < 4) ? 32'd1 : 32'd0);
      edgeStep();
    end
    check("mdu_raw_cnt", 32'(stall_cnt), 32'd3);
    check("mdu_raw_idle", 32'(mdu_busy), 32'd0);

    // Structural stall, then done and a new start on the same cycle
    clearIn(); mdu_start_e = 1; rd_e = 12; settle(); edgeStep();
    clearIn(); mdu_op_d = 1; settle();
    check("struct_stall", 32'(stall_d), 32'd1);
    edgeStep();
    clearIn(); mdu_done = 1; mdu_rd = 12; mdu_start_e = 1; rd_e = 3; settle(); edgeStep();
    check("b2b_busy", 32'(mdu_busy), 32'd1);
    clearIn(); rs2_d = 3; settle();
    check("b2b_pend3", 32'(stall_d), 32'd1);
    edgeStep();
    clearIn(); mdu_done = 1; mdu_rd = 3; settle(); edgeStep();

    // Taken branch overrides a RAW stall
    clearIn(); cnt_clr = 1; mdu_start_e = 1; rd_e = 9; settle(); edgeStep();
    clearIn(); rs1_d = 9; pc_src_e = 1; settle();
    check("br_stall_f", 32'(stall_f), 32'd0);
    check("br_flush_d", 32'(flush_d), 32'd1);
    check("br_flush_e", 32'(flush_e), 32'd1);
    edgeStep();
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd0);
    clearIn(); mdu_done = 1; mdu_rd = 9; settle(); edgeStep();

    // Counter saturation, then clear beats increment
    clearIn(); cnt_clr = 1; settle(); edgeStep();
    for (int i = 0; i < CMAX + 4; i++) begin
      clearIn(); result_src_e = 1; rd_e = 4; rs1_d = 4; settle(); edgeStep();
    end
    check("sat_hold", 32'(stall_cnt), 32'd31);
    clearIn(); result_src_e = 1; rd_e = 4; rs1_d = 4; cnt_clr = 1; settle(); edgeStep();
    check("clr_over_inc", 32'(stall_cnt), 32'd0);

    // Asynchronous reset while BUSY, then a stray done is ignored
    clearIn(); mdu_start_e = 1; rd_e = 6; settle(); edgeStep();
    check("pre_rst_busy", 32'(mdu_busy), 32'd1);
    clearIn();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(mdu_busy), 32'd0);
    modelReset();
    compareAll();
    rst_n = 1'b1;
    edgeStep();
    clearIn(); mdu_done = 1; mdu_rd = 5; settle(); edgeStep();
    check("stray_done", 32'(mdu_busy), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      randIn();
      settle();
      edgeStep();
    end

    clearIn();
    settle();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-index width.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Ports rs1_d, rs2_d, rd_d, input, REG_AW each: decode-stage source and destination indices.
REQ-006 Port mdu_op_d, input, 1: decode instruction is a multi-cycle MUL/DIV.
REQ-007 Ports rs1_e, rs2_e, rd_e, input, REG_AW each: execute-stage indices.
REQ-008 Ports pc_src_e, result_src_e, mdu_start_e, input, 1 each: meaning is taken branch/jump, load in EX, and MDU op issuing from EX.
REQ-009 Ports rd_m, rd_w, input, REG_AW each; regwrite_m, regwrite_w, input, 1 each: later-stage write info.
REQ-010 Ports mdu_done, input, 1; mdu_rd, input, REG_AW: MDU result written to register file this cycle.
REQ-011 Port cnt_clr, input, 1: synchronous counter clear.
REQ-012 Ports stall_f, stall_d, flush_d, flush_e, output, 1 each: pipeline control.
REQ-013 Ports forward_ae, forward_be, output, 2 each: operand select; 00 register file, 01 writeback, 10 memory.
REQ-014 Port mdu_busy, output, 1: one MDU operation is outstanding.
REQ-015 Ports stall_cnt, flush_cnt, output, CNT_W each: performance counters.

Function
REQ-016 Forwarding shall be combinational: forward_ae = 10 if rs1_e==rd_m, regwrite_m=1 and rs1_e!=0; else 01 if rs1_e==rd_w, regwrite_w=1 and rs1_e!=0; else 00. forward_be is identical using rs2_e. M has priority over W.
REQ-017 load_stall = result_src_e & (rd_e!=0) & (rs1_d==rd_e | rs2_d==rd_e).
REQ-018 An MDU FSM shall have two states, IDLE and BUSY, with a pending register pend_rd (REG_AW bits).
REQ-019 IDLE->BUSY on mdu_start_e; pend_rd<=rd_e in the same edge.
REQ-020 BUSY->IDLE on mdu_done when mdu_start_e=0. If mdu_done and mdu_start_e coincide, the FSM stays BUSY and pend_rd loads the new rd_e.
REQ-021 mdu_busy shall equal (state==BUSY).
REQ-022 raw_stall = mdu_busy & !mdu_done & (pend_rd!=0) & (rs1_d==pend_rd | rs2_d==pend_rd | rd_d==pend_rd). This covers both RAW and WAW.
REQ-023 struct_stall = mdu_op_d & ((mdu_busy & !mdu_done) | mdu_start_e).
REQ-024 The register file is write-through, so a stall shall release in the same cycle that mdu_done is high.
REQ-025 Define dstall = load_stall | raw_stall | struct_stall.
REQ-026 stall_f = stall_d = dstall & !pc_src_e. A taken branch overrides the stall.
REQ-027 flush_d = pc_src_e; flush_e = pc_src_e | dstall.
REQ-028 stall_cnt shall increment each cycle stall_d=1; flush_cnt shall increment each cycle pc_src_e=1. Both saturate at all-ones and do not wrap.
REQ-029 cnt_clr=1 shall zero both counters next edge, taking priority over increment.

Reset
REQ-030 While rst_n=0: state=IDLE, pend_rd=0, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-031 After reset, mdu_busy=0 and all stall/flush outputs follow only the combinational load/branch terms.
REQ-032 An MDU operation in flight at reset is abandoned; a later mdu_done while IDLE shall be ignored.

Structure
REQ-033 Package hazard_pkg shall hold the forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the MDU state encoding (IDLE, BUSY).
REQ-034 Each counter shall be one instance of sub-module hazard_sat_counter (parameter W; ports clk, rst_n, clr, inc, count).

Verification
REQ-035 rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs1_e=5 -> forward_ae=10. With rs1_e=0 -> forward_ae=00.
REQ-036 result_src_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle. Repeat with rd_e=0 -> no stall.
REQ-037 Stimulus: mdu_start_e with rd_e=9, then rs1_d=9 held for 4 cycles, mdu_done on cycle 4. Response: stall_d=1 on cycles 1-3, 0 on cycle 4; stall_cnt=3.
REQ-038 While BUSY, mdu_op_d=1 -> stall. mdu_done and mdu_start_e (rd_e=3) in the same cycle -> mdu_busy stays 1 and pend_rd=3.
REQ-039 During raw_stall, pc_src_e=1 -> stall_f=0, flush_d=flush_e=1, flush_cnt+1.
REQ-040 Force stall_cnt to all-ones -> it holds. Asserting cnt_clr together with stall -> 0. Asserting rst_n=0 mid-BUSY -> mdu_busy=0 asynchronously.
